// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the instruction-fetch stage.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1C00_0000;
  localparam int          BR_ZIP_W         = 33;
  localparam int          FS2DS_W          = 64;
  localparam logic [1:0]  SIZE_WORD        = 2'b10;

  // Bits needed to index or count up to (value-1); never less than 1.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// Small synchronous FIFO with flush; used for the PC queue and the instruction buffer.
module sync_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      i_push,
  input  logic                      i_pop,
  input  logic                      i_flush,
  input  logic [WIDTH-1:0]          i_din,
  output logic [WIDTH-1:0]          o_dout,
  output logic                      o_empty,
  output logic                      o_full,
  output logic [clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign w_do_pop  = i_pop & ~o_empty;
  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_dout    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (!resetn || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && !i_flush && w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues word fetches with bounded outstanding requests,
// tags returns with their PC and buffers them for decode; branches cancel in-flight work.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          IBUF_DEPTH = 4,
  parameter int          MAX_OST    = 2
) (
  input  logic                clk,
  input  logic                resetn,
  output logic                inst_sram_req,
  output logic                inst_sram_wr,
  output logic [1:0]          inst_sram_size,
  output logic [3:0]          inst_sram_wstrb,
  output logic [31:0]         inst_sram_addr,
  output logic [31:0]         inst_sram_wdata,
  input  logic                inst_sram_addr_ok,
  input  logic                inst_sram_data_ok,
  input  logic [31:0]         inst_sram_rdata,
  input  logic                ds_allowin,
  input  logic [BR_ZIP_W-1:0] br_zip,
  output logic                fs2ds_valid,
  output logic [FS2DS_W-1:0]  fs2ds_bus
);

  localparam int OW = clog2(MAX_OST + 1);
  localparam int BW = clog2(IBUF_DEPTH + 1);
  localparam int SW = clog2(MAX_OST + IBUF_DEPTH + 1);

  logic [31:0]   r_fetch_pc;
  logic [OW-1:0] r_ost_cnt;
  logic [OW-1:0] r_cancel_cnt;

  logic          w_br_taken;
  logic [31:0]   w_br_target;
  logic          w_accept;
  logic          w_resp;
  logic          w_resp_live;
  logic [OW-1:0] w_ost_next;
  logic          w_credit;
  logic [31:0]   w_pcq_head;
  logic          w_pcq_empty;
  logic          w_pcq_full;
  logic [OW-1:0] w_live;
  logic          w_ibuf_empty;
  logic          w_ibuf_full;
  logic [BW-1:0] w_ibuf_cnt;

  assign w_br_taken  = br_zip[32];
  assign w_br_target = br_zip[31:0];

  // The PC queue holds exactly the live (uncancelled) outstanding requests.
  // Issuing only while live + buffered < depth reserves a buffer slot per live request.
  assign w_credit = (SW'(w_live) + SW'(w_ibuf_cnt)) < SW'(IBUF_DEPTH);

  assign inst_sram_req   = resetn & ~w_br_taken & (r_ost_cnt < OW'(MAX_OST))
                         & ~w_pcq_full & ~w_ibuf_full & w_credit;
  assign inst_sram_addr  = r_fetch_pc;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = SIZE_WORD;
  assign inst_sram_wstrb = 4'b0000;
  assign inst_sram_wdata = 32'h0000_0000;

  assign w_accept    = inst_sram_req & inst_sram_addr_ok;
  // A response with nothing outstanding is a slave protocol error and is dropped.
  assign w_resp      = inst_sram_data_ok & (r_ost_cnt != '0);
  assign w_resp_live = w_resp & (r_cancel_cnt == '0) & ~w_br_taken & ~w_pcq_empty;
  assign w_ost_next  = r_ost_cnt + OW'(w_accept) - OW'(w_resp);

  assign fs2ds_valid = ~w_ibuf_empty & ~w_br_taken;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_fetch_pc   <= RESET_PC;
      r_ost_cnt    <= '0;
      r_cancel_cnt <= '0;
    end else begin
      r_ost_cnt <= w_ost_next;
      if (w_br_taken) begin
        r_fetch_pc   <= w_br_target;
        r_cancel_cnt <= w_ost_next;
      end else begin
        if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_resp && (r_cancel_cnt != '0)) r_cancel_cnt <= r_cancel_cnt - OW'(1);
      end
    end
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OST)
  ) u_pc_queue (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_accept),
    .i_pop   (w_resp_live),
    .i_flush (w_br_taken),
    .i_din   (r_fetch_pc),
    .o_dout  (w_pcq_head),
    .o_empty (w_pcq_empty),
    .o_full  (w_pcq_full),
    .o_count (w_live)
  );

  sync_fifo #(
    .WIDTH (FS2DS_W),
    .DEPTH (IBUF_DEPTH)
  ) u_inst_buf (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_resp_live),
    .i_pop   (fs2ds_valid & ds_allowin),
    .i_flush (w_br_taken),
    .i_din   ({inst_sram_rdata, w_pcq_head}),
    .o_dout  (fs2ds_bus),
    .o_empty (w_ibuf_empty),
    .o_full  (w_ibuf_full),
    .o_count (w_ibuf_cnt)
  );

endmodule
